// File: rtl/car_ctrl.sv
// car_ctrl -- per-frame player-car motion controller.
//
// Converts keyboard levels and a collision flag into the sprite's top-left
// position and visibility. It also keeps the current speed and a saturating
// travelled-distance count. All state advances only on the frame tick, which
// is the first pclk edge where vblnk_in is seen high. The sprite therefore
// never moves during active video.
//
// Ports:
//   pclk      in   pixel clock, rising edge
//   rst       in   asynchronous active-high reset
//   vblnk_in  in   vertical blank from the timing stage
//   start     in   level, leaves IDLE on a tick
//   key_left, key_right, key_up, key_down  in  key levels
//   crash_in  in   collision level
//   xpos      out  [10:0] sprite left edge
//   ypos      out  [10:0] sprite top edge
//   visible   out  sprite enable for the draw stage
//   speed     out  [3:0] current speed
//   distance  out  [15:0] accumulated speed, saturating
//   state_o   out  [1:0] FSM state, for debug and checkers
//
// Handshake: there is no valid/ready handshake. Inputs are levels. They are
// sampled only on tick edges. Outputs are registered and are valid at all
// times.
module car_ctrl #(
    parameter int SCREEN_W     = 800,
    parameter int RECT_WIDTH   = 128,
    parameter int X_MIN        = 0,
    parameter int X_INIT       = 336,
    parameter int Y_INIT       = 440,
    parameter int STEP_X       = 4,
    parameter int MAX_SPEED    = 15,
    parameter int DECAY_FRAMES = 8,
    parameter int CRASH_FRAMES = 64,
    parameter int BLINK_FRAMES = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        crash_in,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        visible,
    output logic [3:0]  speed,
    output logic [15:0] distance,
    output logic [1:0]  state_o
);

    localparam int X_MAX = SCREEN_W - RECT_WIDTH;
    localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int CW = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CRASH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          vblnk_q;
    logic [10:0]   xpos_q, xpos_d;
    logic [10:0]   ypos_q, ypos_d;
    logic          vis_q, vis_d;
    logic [3:0]    speed_q, speed_d;
    logic [15:0]   dist_q, dist_d;
    logic [DW-1:0] decay_q, decay_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [CW-1:0] crash_q, crash_d;

    logic          tick;
    logic [3:0]    speed_dec;
    logic [11:0]   x_wide, x_left, x_right;
    logic [16:0]   dist_sum;

    assign tick = vblnk_in & ~vblnk_q;

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vis_d   = vis_q;
        speed_d = speed_q;
        dist_d  = dist_q;
        decay_d = decay_q;
        blink_d = blink_q;
        crash_d = crash_q;

        speed_dec = (speed_q == 4'd0) ? 4'd0 : speed_q - 4'd1;

        // Steering arithmetic is done 12 bits wide so that clamping happens
        // before any wrap-around could occur.
        x_wide  = {1'b0, xpos_q};
        x_left  = (x_wide < 12'(X_MIN + STEP_X)) ? 12'(X_MIN) : x_wide - 12'(STEP_X);
        x_right = (x_wide + 12'(STEP_X) > 12'(X_MAX)) ? 12'(X_MAX) : x_wide + 12'(STEP_X);
        dist_sum = 17'd0;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_RUN;
                end
                S_RUN: begin
                    if (crash_in) begin
                        state_d = S_CRASH;
                        speed_d = 4'd0;
                        blink_d = '0;
                        crash_d = '0;
                    end else begin
                        if (key_down) begin
                            speed_d = speed_dec;
                            decay_d = '0;
                        end else if (key_up) begin
                            speed_d = (speed_q >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : speed_q + 4'd1;
                            decay_d = '0;
                        end else if (decay_q == DW'(DECAY_FRAMES - 1)) begin
                            decay_d = '0;
                            speed_d = speed_dec;
                        end else begin
                            decay_d = decay_q + DW'(1);
                        end

                        // Steering uses the speed from before this tick.
                        if (speed_q != 4'd0) begin
                            if (key_left && !key_right)      xpos_d = x_left[10:0];
                            else if (key_right && !key_left) xpos_d = x_right[10:0];
                        end

                        ypos_d   = 11'(Y_INIT) - {5'b0, speed_d, 2'b00};
                        dist_sum = {1'b0, dist_q} + {13'b0, speed_d};
                        dist_d   = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
                    end
                end
                S_CRASH: begin
                    speed_d = 4'd0;
                    if (crash_q == CW'(CRASH_FRAMES - 1)) begin
                        // This is the final crash tick. The car returns to the
                        // start position. Distance is kept.
                        state_d = S_IDLE;
                        xpos_d  = 11'(X_INIT);
                        ypos_d  = 11'(Y_INIT);
                        vis_d   = 1'b1;
                        decay_d = '0;
                        blink_d = '0;
                        crash_d = '0;
                    end else begin
                        crash_d = crash_q + CW'(1);
                        if (blink_q == BW'(BLINK_FRAMES - 1)) begin
                            blink_d = '0;
                            vis_d   = ~vis_q;
                        end else begin
                            blink_d = blink_q + BW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vblnk_q <= 1'b0;
            xpos_q  <= 11'(X_INIT);
            ypos_q  <= 11'(Y_INIT);
            vis_q   <= 1'b1;
            speed_q <= 4'd0;
            dist_q  <= 16'd0;
            decay_q <= '0;
            blink_q <= '0;
            crash_q <= '0;
        end else begin
            state_q <= state_d;
            vblnk_q <= vblnk_in;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            vis_q   <= vis_d;
            speed_q <= speed_d;
            dist_q  <= dist_d;
            decay_q <= decay_d;
            blink_q <= blink_d;
            crash_q <= crash_d;
        end
    end

    assign xpos     = xpos_q;
    assign ypos     = ypos_q;
    assign visible  = vis_q;
    assign speed    = speed_q;
    assign distance = dist_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_car_ctrl.sv
module tb_car_ctrl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk_in = 1'b0;
  logic        start = 1'b0;
  logic        key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic        crash_in = 1'b0;
  logic [10:0] xpos, ypos;
  logic        visible;
  logic [3:0]  speed;
  logic [15:0] distance;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 pclk = ~pclk;

  car_ctrl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .start(start),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .crash_in(crash_in), .xpos(xpos), .ypos(ypos), .visible(visible),
    .speed(speed), .distance(distance), .state_o(state_dbg)
  );

  // ---------------- reference model ----------------
  // mode: 0 waiting for start, 1 driving, 2 crashed
  int m_mode, m_x, m_y, m_vis, m_speed, m_dist, m_coast, m_ct;

  task automatic model_reset();
    m_mode = 0; m_x = 336; m_y = 440; m_vis = 1; m_speed = 0;
    m_dist = 0; m_coast = 0; m_ct = 0;
  endtask

  task automatic model_tick(input bit s, l, r, u, d, c);
    int old;
    if (m_mode == 0) begin
      if (s) m_mode = 1;
    end else if (m_mode == 1) begin
      if (c) begin
        m_mode = 2; m_speed = 0; m_ct = 0;
      end else begin
        old = m_speed;
        if (d) begin
          m_speed = (m_speed > 0) ? m_speed - 1 : 0; m_coast = 0;
        end else if (u) begin
          m_speed = (m_speed < 15) ? m_speed + 1 : 15; m_coast = 0;
        end else begin
          m_coast++;
          if (m_coast == 8) begin
            m_coast = 0;
            m_speed = (m_speed > 0) ? m_speed - 1 : 0;
          end
        end
        if (old > 0 && l && !r) m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
        if (old > 0 && r && !l) m_x = (m_x + 4 > 672) ? 672 : m_x + 4;
        m_y = 440 - 4 * m_speed;
        m_dist = (m_dist + m_speed > 65535) ? 65535 : m_dist + m_speed;
      end
    end else begin
      m_ct++;
      if (m_ct == 64) begin
        m_mode = 0; m_x = 336; m_y = 440; m_vis = 1; m_speed = 0; m_coast = 0;
      end else begin
        m_vis = ((m_ct / 4) % 2 == 0) ? 1 : 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One frame: inputs valid at the tick edge, then random input noise for
  // the remaining cycles (it must be ignored), then vblank drops.
  task automatic frame(input bit s, l, r, u, d, c);
    @(negedge pclk);
    start = s; key_left = l; key_right = r; key_up = u; key_down = d; crash_in = c;
    vblnk_in = 1'b1;
    @(posedge pclk); #1;
    model_tick(s, l, r, u, d, c);
    start = 1'($urandom); key_left = 1'($urandom); key_right = 1'($urandom);
    key_up = 1'($urandom); key_down = 1'($urandom); crash_in = 1'($urandom);
    @(negedge pclk);
    @(negedge pclk);
    vblnk_in = 1'b0;
    @(negedge pclk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    checks++;
    if (xpos !== 11'd336 || ypos !== 11'd440 || visible !== 1'b1 || speed !== 4'd0 || distance !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: got x=%0d y=%0d v=%0b s=%0d d=%0d want 336 440 1 0 0",
               xpos, ypos, visible, speed, distance);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (xpos !== 11'd336 || ypos !== 11'd440 || visible !== 1'b1 || speed !== 4'd0) begin
        errors++;
        $display("FAIL idle_hold tick %0d: got x=%0d y=%0d v=%0b s=%0d want 336 440 1 0",
                 i, xpos, ypos, visible, speed);
      end
    end
  endtask

  task automatic test_accel();
    frame(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      frame(0, 0, 0, 1, 0, 0);
      checks++;
      if (speed !== 4'(m_speed) || ypos !== 11'(m_y) || distance !== 16'(m_dist)) begin
        errors++;
        $display("FAIL accel tick %0d: got s=%0d y=%0d d=%0d want s=%0d y=%0d d=%0d",
                 i, speed, ypos, distance, m_speed, m_y, m_dist);
      end
    end
    checks++;
    if (speed !== 4'd15 || ypos !== 11'd380 || distance !== 16'd195) begin
      errors++;
      $display("FAIL accel_final: got s=%0d y=%0d d=%0d want 15 380 195", speed, ypos, distance);
    end
  endtask

  task automatic test_steer();
    for (int i = 1; i <= 90; i++) begin
      frame(0, 0, 1, 1, 0, 0);
      checks++;
      if (xpos !== 11'(m_x) || speed !== 4'(m_speed)) begin
        errors++;
        $display("FAIL steer_right tick %0d: got x=%0d s=%0d want x=%0d s=%0d", i, xpos, speed, m_x, m_speed);
      end
      if (i == 83 || i == 84) begin
        checks++;
        if (xpos !== ((i == 84) ? 11'd672 : 11'd668)) begin
          errors++;
          $display("FAIL steer_right_edge tick %0d: got x=%0d", i, xpos);
        end
      end
    end
    for (int i = 1; i <= 172; i++) begin
      frame(0, 1, 0, 1, 0, 0);
      checks++;
      if (xpos !== 11'(m_x)) begin
        errors++;
        $display("FAIL steer_left tick %0d: got x=%0d want x=%0d", i, xpos, m_x);
      end
    end
    checks++;
    if (xpos !== 11'd0) begin
      errors++;
      $display("FAIL steer_left_floor: got x=%0d want 0", xpos);
    end
    for (int i = 1; i <= 5; i++) frame(0, 1, 1, 1, 0, 0);
    checks++;
    if (xpos !== 11'd0 || speed !== 4'd15) begin
      errors++;
      $display("FAIL steer_both: got x=%0d s=%0d want 0 15", xpos, speed);
    end
  endtask

  task automatic test_coast_brake();
    for (int i = 0; i < 10; i++) frame(0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      frame(0, 0, 0, 0, 0, 0);
      checks++;
      if (speed !== 4'(m_speed) || ypos !== 11'(m_y)) begin
        errors++;
        $display("FAIL coast tick %0d: got s=%0d y=%0d want s=%0d y=%0d", i, speed, ypos, m_speed, m_y);
      end
    end
    checks++;
    if (speed !== 4'd13 || xpos !== 11'd40) begin
      errors++;
      $display("FAIL coast_final: got s=%0d x=%0d want 13 40", speed, xpos);
    end
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 1, 1, 0);
    checks++;
    if (speed !== 4'd10) begin
      errors++;
      $display("FAIL brake_wins: got s=%0d want 10", speed);
    end
    for (int i = 0; i < 12; i++) frame(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      frame(0, 1, 0, 0, 0, 0);
      checks++;
      if (xpos !== 11'd40 || speed !== 4'd0 || ypos !== 11'd440) begin
        errors++;
        $display("FAIL steer_at_zero tick %0d: got x=%0d s=%0d y=%0d want 40 0 440", i, xpos, speed, ypos);
      end
    end
  endtask

  task automatic test_vblnk_hold();
    logic [3:0] s_first;
    logic [15:0] d_first;
    @(negedge pclk);
    key_up = 1'b1; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0; crash_in = 1'b0;
    vblnk_in = 1'b1;
    @(posedge pclk); #1;
    model_tick(0, 0, 0, 1, 0, 0);
    s_first = speed; d_first = distance;
    checks++;
    if (speed !== 4'(m_speed) || distance !== 16'(m_dist)) begin
      errors++;
      $display("FAIL vblnk_first_tick: got s=%0d d=%0d want s=%0d d=%0d", speed, distance, m_speed, m_dist);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk); #1;
      checks++;
      if (speed !== 4'(m_speed) || distance !== 16'(m_dist)) begin
        errors++;
        $display("FAIL vblnk_held cycle %0d: got s=%0d d=%0d want s=%0d d=%0d", i, speed, distance, m_speed, m_dist);
      end
    end
    @(negedge pclk);
    vblnk_in = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_crash();
    int d_before, x_before;
    for (int i = 0; i < 5; i++) frame(0, 0, 0, 1, 0, 0);
    d_before = m_dist; x_before = m_x;
    frame(0, 0, 0, 1, 0, 1);
    checks++;
    if (speed !== 4'd0 || distance !== 16'(d_before) || xpos !== 11'(x_before) || visible !== 1'b1) begin
      errors++;
      $display("FAIL crash_enter: got s=%0d d=%0d x=%0d v=%0b want 0 %0d %0d 1",
               speed, distance, xpos, visible, d_before, x_before);
    end
    for (int k = 1; k <= 64; k++) begin
      frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (visible !== 1'(m_vis) || speed !== 4'(m_speed) || xpos !== 11'(m_x) ||
          ypos !== 11'(m_y) || distance !== 16'(m_dist)) begin
        errors++;
        $display("FAIL crash tick %0d: got v=%0b s=%0d x=%0d y=%0d d=%0d want v=%0d s=%0d x=%0d y=%0d d=%0d",
                 k, visible, speed, xpos, ypos, distance, m_vis, m_speed, m_x, m_y, m_dist);
      end
    end
    checks++;
    if (xpos !== 11'd336 || ypos !== 11'd440 || visible !== 1'b1 || speed !== 4'd0 || distance !== 16'(d_before)) begin
      errors++;
      $display("FAIL crash_exit: got x=%0d y=%0d v=%0b s=%0d d=%0d want 336 440 1 0 %0d",
               xpos, ypos, visible, speed, distance, d_before);
    end
  endtask

  task automatic test_random();
    bit s, l, r, u, d, c;
    for (int i = 0; i < 400; i++) begin
      s = 1'($urandom); l = 1'($urandom); r = 1'($urandom);
      u = ($urandom_range(0, 2) != 0); d = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 29) == 0);
      frame(s, l, r, u, d, c);
      checks++;
      if (xpos !== 11'(m_x) || ypos !== 11'(m_y) || visible !== 1'(m_vis) ||
          speed !== 4'(m_speed) || distance !== 16'(m_dist)) begin
        errors++;
        $display("FAIL random tick %0d: got x=%0d y=%0d v=%0b s=%0d d=%0d want x=%0d y=%0d v=%0d s=%0d d=%0d",
                 i, xpos, ypos, visible, speed, distance, m_x, m_y, m_vis, m_speed, m_dist);
      end
    end
  endtask

  task automatic test_saturation();
    // Leave any crash first, then drive at top speed until distance pins.
    while (m_mode == 2) frame(0, 0, 0, 0, 0, 0);
    if (m_mode == 0) frame(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4400; i++) begin
      frame(0, 0, 0, 1, 0, 0);
      checks++;
      if (distance !== 16'(m_dist)) begin
        errors++;
        $display("FAIL distance tick %0d: got d=%0d want d=%0d", i, distance, m_dist);
      end
    end
    checks++;
    if (distance !== 16'hFFFF) begin
      errors++;
      $display("FAIL distance_saturate: got d=%0d want 65535", distance);
    end
  endtask

  task automatic test_async_reset();
    frame(0, 1, 0, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (xpos !== 11'd336 || ypos !== 11'd440 || visible !== 1'b1 || speed !== 4'd0 || distance !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d v=%0b s=%0d d=%0d want 336 440 1 0 0",
               xpos, ypos, visible, speed, distance);
    end
    // Release with vblank already high: the first edge must act as a tick.
    vblnk_in = 1'b1; start = 1'b1;
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0; crash_in = 1'b0;
    @(negedge pclk);
    rst = 1'b0;
    @(posedge pclk); #1;
    model_tick(1, 0, 0, 0, 0, 0);
    @(negedge pclk);
    vblnk_in = 1'b0; start = 1'b0;
    @(negedge pclk);
    frame(0, 0, 0, 1, 0, 0);
    checks++;
    if (speed !== 4'd1 || speed !== 4'(m_speed) || ypos !== 11'd436) begin
      errors++;
      $display("FAIL reset_vblank_high_tick: got s=%0d y=%0d want 1 436", speed, ypos);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_accel();
    test_steer();
    test_coast_brake();
    test_vblnk_hold();
    test_crash();
    test_random();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
